// File: rtl/memory_access_unit_if.sv
// rtl/memory_access_unit_if.sv - data-memory request/response channel between the MEM stage and data memory
interface memory_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_byte_en;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - MEM pipeline stage: issues data-memory accesses, aligns load/store data, drives MEM/WB registers
module memory_access_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  memory_access_unit_if.master mem,
  input  logic                 in_valid,
  input  logic                 control_mem_read,
  input  logic                 control_mem_write,
  input  logic                 control_reg_write,
  input  logic                 control_mem_to_reg,
  input  logic [2:0]           funct3,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          register_file_data2,
  input  logic [4:0]           register_file_rd,
  output logic                 stall,
  output logic                 o_valid,
  output logic                 o_mem_fault,
  output logic                 o_control_reg_write,
  output logic                 o_control_mem_to_reg,
  output logic [31:0]          o_alu_result,
  output logic [31:0]          o_mem_data,
  output logic [4:0]           o_register_file_rd
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        cap_load;
  logic        cap_reg_write;
  logic        cap_mem_to_reg;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_alu;
  logic [4:0]  cap_rd;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        op_fault;
  logic        start_access;
  logic        ack_hit;
  logic        timeout_hit;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic [31:0] lane_shifted;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Read wins when both controls are set, so a conflicting decode never writes memory.
  assign is_load  = control_mem_read;
  assign is_store = control_mem_write & ~control_mem_read;
  assign is_mem   = is_load | is_store;

  always_comb begin
    op_fault = 1'b0;
    if (is_load && (funct3 == 3'd3 || funct3[2:1] == 2'b11))
      op_fault = 1'b1;
    if (is_store && funct3 >= 3'd3)
      op_fault = 1'b1;
    if (is_mem && funct3[1:0] == 2'b01 && alu_result[0])
      op_fault = 1'b1;
    if (is_mem && funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00)
      op_fault = 1'b1;
  end

  assign start_access = (state == IDLE) && in_valid && is_mem && !op_fault;
  assign ack_hit      = (state == BUSY) && mem.mem_ack;
  assign timeout_hit  = (state == BUSY) && !mem.mem_ack && (wait_cnt == LAST_WAIT);

  // Gated by rst_n so reset drops stall immediately even while inputs still request an access.
  assign stall = rst_n & (start_access | ((state == BUSY) & ~ack_hit & ~timeout_hit));

  always_comb begin
    store_be   = 4'b0000;
    store_data = 32'd0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          store_be   = 4'b0001 << alu_result[1:0];
          store_data = {4{register_file_data2[7:0]}};
        end
        2'b01: begin
          store_be   = alu_result[1] ? 4'b1100 : 4'b0011;
          store_data = {2{register_file_data2[15:0]}};
        end
        default: begin
          store_be   = 4'b1111;
          store_data = register_file_data2;
        end
      endcase
    end
  end

  assign lane_shifted = mem.mem_rdata >> {cap_alu[1:0], 3'b000};
  assign half_sel     = cap_alu[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    case (cap_funct3)
      3'd0:    load_data = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {24'd0, lane_shifted[7:0]};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      wait_cnt             <= 8'd0;
      mem.mem_req          <= 1'b0;
      mem.mem_we           <= 1'b0;
      mem.mem_addr         <= '0;
      mem.mem_byte_en      <= 4'b0000;
      mem.mem_wdata        <= 32'd0;
      cap_load             <= 1'b0;
      cap_reg_write        <= 1'b0;
      cap_mem_to_reg       <= 1'b0;
      cap_funct3           <= 3'd0;
      cap_alu              <= 32'd0;
      cap_rd               <= 5'd0;
      o_valid              <= 1'b0;
      o_mem_fault          <= 1'b0;
      o_control_reg_write  <= 1'b0;
      o_control_mem_to_reg <= 1'b0;
      o_alu_result         <= 32'd0;
      o_mem_data           <= 32'd0;
      o_register_file_rd   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (!in_valid) begin
            o_valid             <= 1'b0;
            o_control_reg_write <= 1'b0;
          end else if (!is_mem || op_fault) begin
            o_valid              <= 1'b1;
            o_mem_fault          <= op_fault;
            o_control_reg_write  <= control_reg_write & ~op_fault;
            o_control_mem_to_reg <= control_mem_to_reg;
            o_alu_result         <= alu_result;
            o_mem_data           <= 32'd0;
            o_register_file_rd   <= register_file_rd;
          end else begin
            state           <= BUSY;
            mem.mem_req     <= 1'b1;
            mem.mem_we      <= is_store;
            mem.mem_addr    <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
            mem.mem_byte_en <= store_be;
            mem.mem_wdata   <= store_data;
            cap_load        <= is_load;
            cap_reg_write   <= control_reg_write;
            cap_mem_to_reg  <= control_mem_to_reg;
            cap_funct3      <= funct3;
            cap_alu         <= alu_result;
            cap_rd          <= register_file_rd;
            o_valid             <= 1'b0;
            o_control_reg_write <= 1'b0;
          end
        end
        BUSY: begin
          if (ack_hit || timeout_hit) begin
            state                <= IDLE;
            wait_cnt             <= 8'd0;
            mem.mem_req          <= 1'b0;
            mem.mem_we           <= 1'b0;
            o_valid              <= 1'b1;
            o_mem_fault          <= timeout_hit;
            o_control_reg_write  <= cap_reg_write & ack_hit;
            o_control_mem_to_reg <= cap_mem_to_reg;
            o_alu_result         <= cap_alu;
            o_mem_data           <= (ack_hit && cap_load) ? load_data : 32'd0;
            o_register_file_rd   <= cap_rd;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
